// File: rtl/riscv_marb_pkg.sv
// riscv_marb_pkg: shared types and default sizes for the memory arbiter
package riscv_marb_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;
  typedef enum logic {GNT_DC, GNT_IC} grant_e;
  localparam int DATA_WIDTH_D = 128;
  localparam int S_ADDR_D = 10;
endpackage

// File: rtl/riscv_marb_rr_arbiter.sv
// riscv_marb_rr_arbiter: two-requester round-robin pick, req[0]=dcache, req[1]=icache
module riscv_marb_rr_arbiter
  import riscv_marb_pkg::*;
(
  input  logic [1:0] req,
  input  grant_e     last,
  input  logic       enable,
  output grant_e     grant
);
  // lone requester wins; under contention the cache not served last wins
  always_comb grant = (enable && (req == 2'b11 ? last == GNT_DC : req[1])) ? GNT_IC : GNT_DC;
endmodule

// File: rtl/riscv_mem_arbiter.sv
// riscv_mem_arbiter: merges icache refills and dcache refills/write-backs onto one block-memory bus
module riscv_mem_arbiter
  import riscv_marb_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_D,
  parameter int S_ADDR     = S_ADDR_D
) (
  input  logic                  i_riscv_marb_clk,
  input  logic                  i_riscv_marb_rst,
  input  logic                  i_riscv_marb_dc_wren,
  input  logic                  i_riscv_marb_dc_rden,
  input  logic [S_ADDR-1:0]     i_riscv_marb_dc_addr,
  input  logic [DATA_WIDTH-1:0] i_riscv_marb_dc_wdata,
  output logic                  o_riscv_marb_dc_ready,
  output logic [DATA_WIDTH-1:0] o_riscv_marb_dc_rdata,
  input  logic                  i_riscv_marb_ic_rden,
  input  logic [S_ADDR-1:0]     i_riscv_marb_ic_addr,
  output logic                  o_riscv_marb_ic_ready,
  output logic [DATA_WIDTH-1:0] o_riscv_marb_ic_rdata,
  output logic                  o_riscv_marb_ext_req,
  output logic                  o_riscv_marb_ext_we,
  output logic [S_ADDR-1:0]     o_riscv_marb_ext_addr,
  output logic [DATA_WIDTH-1:0] o_riscv_marb_ext_wdata,
  input  logic                  i_riscv_marb_ext_ack,
  input  logic [DATA_WIDTH-1:0] i_riscv_marb_ext_rdata
);
  state_e     state, state_n;
  grant_e     gnt, gnt_n, rr_last;
  logic [1:0] req;
  logic       take, done, dc_wr;
  assign req   = {i_riscv_marb_ic_rden, i_riscv_marb_dc_wren | i_riscv_marb_dc_rden};
  assign take  = state == IDLE && |req;
  assign done  = state == BUSY && i_riscv_marb_ext_ack;
  assign dc_wr = gnt_n == GNT_DC && i_riscv_marb_dc_wren;
  riscv_marb_rr_arbiter u_rr (
    .req    (req),
    .last   (rr_last),
    .enable (state == IDLE),
    .grant  (gnt_n)
  );
  // state register
  always_ff @(posedge i_riscv_marb_clk) state <= !i_riscv_marb_rst ? IDLE : state_n;
  // one transaction at a time: launch, wait for ack, one response cycle
  always_comb state_n = state == IDLE ? (|req ? BUSY : IDLE) : state == BUSY ? (i_riscv_marb_ext_ack ? RESP : BUSY) : IDLE;
  // ext bus launch, response capture and round-robin history; reset starts history at dcache so icache wins first
  always_ff @(posedge i_riscv_marb_clk) begin
    if (!i_riscv_marb_rst) begin
      gnt                    <= GNT_DC;
      rr_last                <= GNT_DC;
      o_riscv_marb_ext_req   <= 1'b0;
      o_riscv_marb_ext_we    <= 1'b0;
      o_riscv_marb_ext_addr  <= '0;
      o_riscv_marb_ext_wdata <= '0;
      o_riscv_marb_dc_ready  <= 1'b0;
      o_riscv_marb_ic_ready  <= 1'b0;
      o_riscv_marb_dc_rdata  <= '0;
      o_riscv_marb_ic_rdata  <= '0;
    end else begin
      o_riscv_marb_dc_ready <= done && gnt == GNT_DC;
      o_riscv_marb_ic_ready <= done && gnt == GNT_IC;
      if (take) begin
        gnt                    <= gnt_n;
        o_riscv_marb_ext_req   <= 1'b1;
        o_riscv_marb_ext_we    <= dc_wr;
        o_riscv_marb_ext_addr  <= gnt_n == GNT_DC ? i_riscv_marb_dc_addr : i_riscv_marb_ic_addr;
        o_riscv_marb_ext_wdata <= dc_wr ? i_riscv_marb_dc_wdata : '0;
      end
      if (done) o_riscv_marb_ext_req <= 1'b0;
      if (done && !o_riscv_marb_ext_we && gnt == GNT_DC) o_riscv_marb_dc_rdata <= i_riscv_marb_ext_rdata;
      if (done && !o_riscv_marb_ext_we && gnt == GNT_IC) o_riscv_marb_ic_rdata <= i_riscv_marb_ext_rdata;
      if (state == RESP) rr_last <= gnt;
    end
  end
endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// tb_riscv_mem_arbiter: directed and randomized checks of the memory arbiter against a block-memory model
module tb_riscv_mem_arbiter;
  localparam int DW = 128;
  localparam int AW = 10;
  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          dc_wren = 1'b0, dc_rden = 1'b0, ic_rden = 1'b0, ext_ack = 1'b0;
  logic [AW-1:0] dc_addr = '0, ic_addr = '0;
  logic [DW-1:0] dc_wdata = '0, ext_rdata = '0;
  logic          dc_ready, ic_ready, ext_req, ext_we;
  logic [DW-1:0] dc_rdata, ic_rdata, ext_wdata;
  logic [AW-1:0] ext_addr;
  logic [DW-1:0] mem [1024];
  int            n_chk = 0;
  int            n_fail = 0;
  always #5 clk = ~clk;
  riscv_mem_arbiter #(.DATA_WIDTH(DW), .S_ADDR(AW)) dut (
    .i_riscv_marb_clk       (clk),
    .i_riscv_marb_rst       (rst),
    .i_riscv_marb_dc_wren   (dc_wren),
    .i_riscv_marb_dc_rden   (dc_rden),
    .i_riscv_marb_dc_addr   (dc_addr),
    .i_riscv_marb_dc_wdata  (dc_wdata),
    .o_riscv_marb_dc_ready  (dc_ready),
    .o_riscv_marb_dc_rdata  (dc_rdata),
    .i_riscv_marb_ic_rden   (ic_rden),
    .i_riscv_marb_ic_addr   (ic_addr),
    .o_riscv_marb_ic_ready  (ic_ready),
    .o_riscv_marb_ic_rdata  (ic_rdata),
    .o_riscv_marb_ext_req   (ext_req),
    .o_riscv_marb_ext_we    (ext_we),
    .o_riscv_marb_ext_addr  (ext_addr),
    .o_riscv_marb_ext_wdata (ext_wdata),
    .i_riscv_marb_ext_ack   (ext_ack),
    .i_riscv_marb_ext_rdata (ext_rdata)
  );
  function automatic logic [DW-1:0] rnd_blk();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // acts as the external memory for one transaction; returns at the negedge of the ready cycle
  task automatic mem_txn(input int dly, output logic we, output logic [AW-1:0] a,
                         output logic [DW-1:0] wd, output int lat);
    int n;
    n = 0;
    while (ext_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    lat = n;
    chk("ext_req_rise", DW'(ext_req), DW'(1));
    we = ext_we;
    a  = ext_addr;
    wd = ext_wdata;
    for (int i = 0; i < dly; i++) begin
      tick();
      chk("ext_req_held", {ext_req, ext_we, ext_addr}, {1'b1, we, a});
      chk("busy_no_ready", {ic_ready, dc_ready}, '0);
    end
    ext_rdata = we ? rnd_blk() : mem[a];
    if (we) mem[a] = wd;
    ext_ack = 1'b1;
    tick();
    ext_ack   = 1'b0;
    ext_rdata = rnd_blk();
    chk("ext_req_drop", DW'(ext_req), '0);
  endtask
  logic          we, last_ic, gic, ewe;
  logic [AW-1:0] a, ia, da;
  logic [DW-1:0] wd, dwd, exp_ic_rd, exp_dc_rd;
  int            lat;
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = rnd_blk();
    // reset state and idle ack
    repeat (2) tick();
    chk("rst_outputs", {ext_req, ext_we, ext_addr, ic_ready, dc_ready}, '0);
    rst = 1'b1;
    tick();
    chk("idle_wdata", ext_wdata, '0);
    chk("idle_rdata", ic_rdata | dc_rdata, '0);
    ext_ack   = 1'b1;
    ext_rdata = rnd_blk();
    tick();
    ext_ack = 1'b0;
    tick();
    chk("idle_ack_ignored", {ext_req, ic_ready, dc_ready}, '0);
    chk("idle_ack_rdata", ic_rdata | dc_rdata, '0);
    // icache refill
    mem[10'h012] = {16{8'hA5}};
    ic_rden = 1'b1;
    ic_addr = 10'h012;
    mem_txn(2, we, a, wd, lat);
    chk("ic_lat", DW'(lat), DW'(1));
    chk("ic_we_addr", {we, a}, {1'b0, 10'h012});
    chk("ic_ready", {ic_ready, dc_ready}, 2'b10);
    chk("ic_rdata", ic_rdata, {16{8'hA5}});
    ic_rden = 1'b0;
    tick();
    chk("ic_pulse_end", {ic_ready, dc_ready}, '0);
    chk("ic_rdata_held", ic_rdata, {16{8'hA5}});
    // dcache write-back then refill
    dc_wren  = 1'b1;
    dc_rden  = 1'b1;
    dc_addr  = 10'h3FF;
    dc_wdata = 128'h1234;
    mem_txn(1, we, a, wd, lat);
    chk("wb_we_addr", {we, a}, {1'b1, 10'h3FF});
    chk("wb_wdata", wd, 128'h1234);
    chk("wb_ready", {ic_ready, dc_ready}, 2'b01);
    chk("wb_rdata_kept", dc_rdata, '0);
    dc_wren = 1'b0;
    tick();
    chk("wb_pulse_end", DW'(dc_ready), '0);
    mem_txn(0, we, a, wd, lat);
    chk("rf_lat", DW'(lat), DW'(1));
    chk("rf_we_addr", {we, a}, {1'b0, 10'h3FF});
    chk("rf_rdata", {dc_ready, dc_rdata}, {1'b1, 128'h1234});
    dc_rden = 1'b0;
    tick();
    // contention from reset alternates IC, DC, IC, DC
    rst     = 1'b0;
    ic_rden = 1'b1;
    dc_rden = 1'b1;
    ic_addr = 10'h055;
    dc_addr = 10'h0AA;
    repeat (2) tick();
    rst = 1'b1;
    for (int t = 0; t < 4; t++) begin
      mem_txn($urandom_range(0, 2), we, a, wd, lat);
      chk("rr_addr", DW'(a), (t % 2 == 0) ? DW'(10'h055) : DW'(10'h0AA));
      chk("rr_ready", {ic_ready, dc_ready}, (t % 2 == 0) ? DW'(2) : DW'(1));
      tick();
    end
    ic_rden = 1'b0;
    dc_rden = 1'b0;
    repeat (2) tick();
    // zero-wait memory and back-to-back spacing
    ic_rden = 1'b1;
    ic_addr = 10'h001;
    mem_txn(0, we, a, wd, lat);
    chk("zw_lat", DW'(lat), DW'(1));
    chk("zw_ready", {ic_ready, ic_rdata}, {1'b1, mem[10'h001]});
    ic_rden = 1'b0;
    dc_rden = 1'b1;
    dc_addr = 10'h002;
    mem_txn(0, we, a, wd, lat);
    chk("b2b_gap", DW'(lat), DW'(2));
    chk("b2b_ready", {dc_ready, dc_rdata}, {1'b1, mem[10'h002]});
    dc_rden = 1'b0;
    tick();
    // reset while busy
    ic_rden = 1'b1;
    ic_addr = 10'h100;
    repeat (2) tick();
    chk("rb_busy", DW'(ext_req), DW'(1));
    rst     = 1'b0;
    ic_rden = 1'b0;
    tick();
    chk("rb_req_drop", DW'(ext_req), '0);
    rst = 1'b1;
    tick();
    ext_ack = 1'b1;
    tick();
    ext_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("rb_no_ready", {ext_req, ic_ready, dc_ready}, '0);
      tick();
    end
    dc_rden = 1'b1;
    dc_addr = 10'h0F0;
    mem_txn(1, we, a, wd, lat);
    chk("rb_fresh", {dc_ready, a, dc_rdata}, {1'b1, 10'h0F0, mem[10'h0F0]});
    dc_rden = 1'b0;
    tick();
    // randomized traffic against the memory model
    rst = 1'b0;
    repeat (2) tick();
    rst       = 1'b1;
    last_ic   = 1'b0;
    exp_ic_rd = '0;
    exp_dc_rd = '0;
    tick();
    for (int it = 0; it < 40; it++) begin
      ia       = AW'($urandom());
      da       = AW'($urandom());
      dwd      = rnd_blk();
      ic_addr  = ia;
      dc_addr  = da;
      dc_wdata = dwd;
      dc_wren  = 1'($urandom());
      dc_rden  = 1'($urandom());
      ic_rden  = !(dc_wren || dc_rden) || 1'($urandom());
      while (ic_rden || dc_wren || dc_rden) begin
        gic = ic_rden && (!(dc_wren || dc_rden) || !last_ic);
        ewe = !gic && dc_wren;
        mem_txn($urandom_range(0, 3), we, a, wd, lat);
        chk("rnd_lat", DW'(lat), DW'(1));
        chk("rnd_we_addr", {we, a}, {ewe, gic ? ia : da});
        chk("rnd_wdata", wd, ewe ? dwd : '0);
        if (gic) exp_ic_rd = mem[ia];
        else if (!ewe) exp_dc_rd = mem[da];
        chk("rnd_ready", {ic_ready, dc_ready}, {gic, !gic});
        chk("rnd_ic_rdata", ic_rdata, exp_ic_rd);
        chk("rnd_dc_rdata", dc_rdata, exp_dc_rd);
        last_ic = gic;
        if (gic) ic_rden = 1'b0;
        else if (ewe) dc_wren = 1'b0;
        else dc_rden = 1'b0;
        tick();
        chk("rnd_pulse_end", {ic_ready, dc_ready}, '0);
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
